// File: rtl/multi_channel_wave_gen_pkg.sv
// Shared types for the multi-channel square-wave / PWM generator.
package wave_gen_pkg;

  // Storage width for M/N fields; channels zero-extend their B-bit values.
  localparam int MAX_B = 16;

  typedef enum logic {
    MODE_CONT    = 1'b0,
    MODE_ONESHOT = 1'b1
  } mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } chan_state_t;

  typedef struct packed {
    logic [MAX_B-1:0] m;
    logic [MAX_B-1:0] n;
    mode_t            mode;
  } shadow_t;

  // Period length in time-units; one extra bit so M=N=max never overflows.
  function automatic logic [MAX_B:0] period_len(input shadow_t s);
    return {1'b0, s.m} + {1'b0, s.n};
  endfunction

endpackage

// File: rtl/multi_channel_wave_gen_if.sv
// Shadow-register write port shared by all channels.
interface multi_channel_wave_gen_if #(
  parameter int B  = 4,
  parameter int CH = 4
) ();
  localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

  logic           wr_en;
  logic [CHW-1:0] wr_ch;
  logic [B-1:0]   wr_m;
  logic [B-1:0]   wr_n;
  logic           wr_mode;

  modport master (output wr_en, wr_ch, wr_m, wr_n, wr_mode);
  modport slave  (input  wr_en, wr_ch, wr_m, wr_n, wr_mode);
endinterface

// File: rtl/multi_channel_wave_gen_channel.sv
// One generator channel: shadow/active registers, IDLE/RUN FSM, phase counter.
module wave_gen_channel
  import wave_gen_pkg::*;
#(
  parameter int B = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic         en,
  input  logic         trig,
  input  logic         wr,
  input  logic [B-1:0] wr_m,
  input  logic [B-1:0] wr_n,
  input  logic         wr_mode,
  output logic         wave_out,
  output logic         busy,
  output logic         period_done
);

  shadow_t     sh_q, sh_d;
  shadow_t     act_q, act_d;
  chan_state_t state_q, state_d;
  logic [B:0]  p_q, p_d;
  logic        pend_q, pend_d;
  logic        wave_q, wave_d;
  logic        done_q, done_d;

  logic [MAX_B:0] sh_len;
  logic [MAX_B:0] act_last;
  logic [MAX_B:0] p_ext;

  // Next-state, shadow update and output computation.
  always_comb begin
    sh_d    = sh_q;
    act_d   = act_q;
    state_d = state_q;
    p_d     = p_q;
    pend_d  = pend_q;
    wave_d  = wave_q;
    done_d  = 1'b0;

    sh_len   = period_len(sh_q);
    act_last = period_len(act_q) - (MAX_B+1)'(1);
    p_ext    = (MAX_B+1)'(p_q);

    if (wr) begin
      sh_d.m    = MAX_B'(wr_m);
      sh_d.n    = MAX_B'(wr_n);
      sh_d.mode = wr_mode ? MODE_ONESHOT : MODE_CONT;
    end

    if (!en) begin
      // Disable acts on the clock edge, not the tick, and suppresses period_done.
      state_d = ST_IDLE;
      wave_d  = 1'b0;
      pend_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          wave_d = 1'b0;
          if (trig && (sh_q.mode == MODE_ONESHOT)) pend_d = 1'b1;
          if (tick && ((sh_q.mode == MODE_CONT) || pend_q) && (sh_len != '0)) begin
            act_d   = sh_q;
            p_d     = '0;
            state_d = ST_RUN;
            pend_d  = 1'b0;
            wave_d  = (sh_q.m != '0);
          end
        end
        ST_RUN: begin
          if (tick) begin
            if (p_ext == act_last) begin
              done_d = 1'b1;
              if ((act_q.mode == MODE_CONT) && (sh_len != '0)) begin
                act_d  = sh_q;
                p_d    = '0;
                wave_d = (sh_q.m != '0);
              end else begin
                state_d = ST_IDLE;
                wave_d  = 1'b0;
              end
            end else begin
              p_d    = p_q + (B+1)'(1);
              wave_d = ((p_ext + (MAX_B+1)'(1)) < {1'b0, act_q.m});
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q    <= '0;
      act_q   <= '0;
      state_q <= ST_IDLE;
      p_q     <= '0;
      pend_q  <= 1'b0;
      wave_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      sh_q    <= sh_d;
      act_q   <= act_d;
      state_q <= state_d;
      p_q     <= p_d;
      pend_q  <= pend_d;
      wave_q  <= wave_d;
      done_q  <= done_d;
    end
  end

  assign wave_out    = wave_q;
  assign busy        = (state_q == ST_RUN);
  assign period_done = done_q;

endmodule

// File: rtl/multi_channel_wave_gen.sv
// Multi-channel PWM generator top: shared prescaler, write decode, channel array.
module multi_channel_wave_gen
  import wave_gen_pkg::*;
#(
  parameter int B        = 4,
  parameter int CH       = 4,
  parameter int TICK_DIV = 10
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [CH-1:0]            en,
  input  logic [CH-1:0]            trig,
  multi_channel_wave_gen_if.slave  wr_bus,
  output logic [CH-1:0]            waveOut,
  output logic [CH-1:0]            busy,
  output logic [CH-1:0]            period_done
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick;
  logic [CH-1:0] wr_sel;

  // Free-running prescaler; tick marks the last cycle of each time-unit.
  always_comb begin
    tick  = (cnt_q == CW'(TICK_DIV - 1));
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  // Prescaler register.
  always_ff @(posedge CLK) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Write decode; out-of-range channel indices select nothing.
  always_comb begin
    wr_sel = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      wr_sel[i] = wr_bus.wr_en && (32'(wr_bus.wr_ch) == i);
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_ch
    wave_gen_channel #(.B(B)) u_ch (
      .clk         (CLK),
      .rst         (RST),
      .tick        (tick),
      .en          (en[g]),
      .trig        (trig[g]),
      .wr          (wr_sel[g]),
      .wr_m        (wr_bus.wr_m),
      .wr_n        (wr_bus.wr_n),
      .wr_mode     (wr_bus.wr_mode),
      .wave_out    (waveOut[g]),
      .busy        (busy[g]),
      .period_done (period_done[g])
    );
  end

endmodule

// File: tb/tb_multi_channel_wave_gen.sv
// Directed bench for multi_channel_wave_gen (B=4, CH=4, TICK_DIV=10).
module tb_multi_channel_wave_gen;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] en;
  logic [3:0] trig;
  logic [3:0] waveOut;
  logic [3:0] busy;
  logic [3:0] period_done;

  int total = 0;
  int bad   = 0;

  multi_channel_wave_gen_if #(.B(4), .CH(4)) wr_bus ();

  multi_channel_wave_gen #(.B(4), .CH(4), .TICK_DIV(10)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .en          (en),
    .trig        (trig),
    .wr_bus      (wr_bus),
    .waveOut     (waveOut),
    .busy        (busy),
    .period_done (period_done)
  );

  always #5 CLK = ~CLK;

  // All stimulus changes and samples happen on the falling edge.
  task automatic write_shadow(input int ch, input int m, input int n, input int mode);
    wr_bus.wr_ch   = 2'(ch);
    wr_bus.wr_m    = 4'(m);
    wr_bus.wr_n    = 4'(n);
    wr_bus.wr_mode = mode[0];
    wr_bus.wr_en   = 1'b1;
    @(negedge CLK);
    wr_bus.wr_en   = 1'b0;
  endtask

  task automatic do_reset;
    RST          = 1'b1;
    en           = '0;
    trig         = '0;
    wr_bus.wr_en = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic wait_level(input int ch, input logic val, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (waveOut[ch] === val) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
  endtask

  task automatic run_len(input int ch, input logic val, output int n);
    n = 0;
    while (waveOut[ch] === val && n < 400) begin
      n++;
      @(negedge CLK);
    end
  endtask

  task automatic done_gap(input int ch, output int gap);
    int w;
    w = 0;
    while (period_done[ch] !== 1'b1 && w < 400) begin
      w++;
      @(negedge CLK);
    end
    gap = 0;
    do begin
      @(negedge CLK);
      gap++;
    end while (period_done[ch] !== 1'b1 && gap < 400);
  endtask

  task automatic test_reset;
    RST = 1'b1;
    en = '0; trig = '0;
    wr_bus.wr_en = 1'b0; wr_bus.wr_ch = '0; wr_bus.wr_m = '0; wr_bus.wr_n = '0; wr_bus.wr_mode = 1'b0;
    repeat (3) @(negedge CLK);
    total++; if (waveOut !== 4'b0) begin bad++; $display("FAIL reset_wave: got %b expected 0000", waveOut); end
    total++; if (busy !== 4'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0000", busy); end
    total++; if (period_done !== 4'b0) begin bad++; $display("FAIL reset_done: got %b expected 0000", period_done); end
    RST = 1'b0;
    en  = 4'b1111;
    repeat (40) @(negedge CLK);
    total++; if (waveOut !== 4'b0 || busy !== 4'b0) begin bad++; $display("FAIL unprogrammed_idle: wave %b busy %b expected 0000", waveOut, busy); end
  endtask

  task automatic test_continuous;
    bit ok; int h, l, h2, g;
    do_reset;
    write_shadow(0, 2, 1, 0);
    en[0] = 1'b1;
    wait_level(0, 1'b1, ok);
    total++; if (!ok) begin bad++; $display("FAIL cont_start: got no high expected high within bound"); end
    run_len(0, 1'b1, h);
    run_len(0, 1'b0, l);
    run_len(0, 1'b1, h2);
    total++; if (h !== 20) begin bad++; $display("FAIL cont_high: got %0d expected 20", h); end
    total++; if (l !== 10) begin bad++; $display("FAIL cont_low: got %0d expected 10", l); end
    total++; if (h2 !== 20) begin bad++; $display("FAIL cont_high2: got %0d expected 20", h2); end
    total++; if (waveOut[3:1] !== 3'b0 || busy[3:1] !== 3'b0) begin bad++; $display("FAIL cont_others: wave %b busy %b expected 000", waveOut[3:1], busy[3:1]); end
    done_gap(0, g);
    total++; if (g !== 30) begin bad++; $display("FAIL cont_done_gap: got %0d expected 30", g); end
  endtask

  task automatic test_duty;
    bit ok; int e1, e2, e3, g, h, l;
    do_reset;
    write_shadow(1, 0, 3, 0);
    write_shadow(2, 3, 0, 0);
    write_shadow(3, 0, 0, 0);
    en = 4'b1110;
    repeat (30) @(negedge CLK);
    e1 = 0; e2 = 0; e3 = 0;
    for (int i = 0; i < 60; i++) begin
      if (waveOut[1] !== 1'b0 || busy[1] !== 1'b1) e1++;
      if (waveOut[2] !== 1'b1) e2++;
      if (waveOut[3] !== 1'b0 || busy[3] !== 1'b0) e3++;
      @(negedge CLK);
    end
    total++; if (e1 != 0) begin bad++; $display("FAIL duty_m0: bad samples %0d expected 0", e1); end
    total++; if (e2 != 0) begin bad++; $display("FAIL duty_n0: bad samples %0d expected 0", e2); end
    total++; if (e3 != 0) begin bad++; $display("FAIL duty_mn0_idle: bad samples %0d expected 0", e3); end
    done_gap(1, g);
    total++; if (g !== 30) begin bad++; $display("FAIL duty_m0_gap: got %0d expected 30", g); end
    done_gap(2, g);
    total++; if (g !== 30) begin bad++; $display("FAIL duty_n0_gap: got %0d expected 30", g); end
    write_shadow(3, 15, 15, 0);
    wait_level(3, 1'b1, ok);
    total++; if (!ok) begin bad++; $display("FAIL max_start: got no high expected high within bound"); end
    run_len(3, 1'b1, h);
    run_len(3, 1'b0, l);
    total++; if (h !== 150) begin bad++; $display("FAIL max_high: got %0d expected 150", h); end
    total++; if (l !== 150) begin bad++; $display("FAIL max_low: got %0d expected 150", l); end
  endtask

  task automatic test_oneshot;
    int hi, bz, dn;
    do_reset;
    write_shadow(1, 3, 2, 1);
    en[1] = 1'b1;
    repeat (30) @(negedge CLK);
    total++; if (waveOut[1] !== 1'b0 || busy[1] !== 1'b0) begin bad++; $display("FAIL oneshot_wait: wave %b busy %b expected 0 0", waveOut[1], busy[1]); end
    trig[1] = 1'b1;
    @(negedge CLK);
    trig[1] = 1'b0;
    hi = 0; bz = 0; dn = 0;
    for (int i = 0; i < 200; i++) begin
      trig[1] = (i == 20);
      if (waveOut[1] === 1'b1) hi++;
      if (busy[1] === 1'b1) bz++;
      if (period_done[1] === 1'b1) dn++;
      @(negedge CLK);
    end
    trig[1] = 1'b0;
    total++; if (hi !== 30) begin bad++; $display("FAIL oneshot_high: got %0d expected 30", hi); end
    total++; if (bz !== 50) begin bad++; $display("FAIL oneshot_busy: got %0d expected 50", bz); end
    total++; if (dn !== 1) begin bad++; $display("FAIL oneshot_done_count: got %0d expected 1", dn); end
  endtask

  task automatic test_update;
    bit ok; int x, l1, h2, l2;
    do_reset;
    write_shadow(0, 2, 1, 0);
    en[0] = 1'b1;
    wait_level(0, 1'b1, ok);
    repeat (5) @(negedge CLK);
    write_shadow(0, 1, 4, 0);
    run_len(0, 1'b1, x);
    run_len(0, 1'b0, l1);
    run_len(0, 1'b1, h2);
    run_len(0, 1'b0, l2);
    total++; if (!ok || x !== 14) begin bad++; $display("FAIL upd_rest_high: got %0d expected 14", x); end
    total++; if (l1 !== 10) begin bad++; $display("FAIL upd_old_low: got %0d expected 10", l1); end
    total++; if (h2 !== 10) begin bad++; $display("FAIL upd_new_high: got %0d expected 10", h2); end
    total++; if (l2 !== 40) begin bad++; $display("FAIL upd_new_low: got %0d expected 40", l2); end
  endtask

  task automatic test_enable_drop;
    bit ok; int e;
    do_reset;
    write_shadow(0, 2, 1, 0);
    en[0] = 1'b1;
    wait_level(0, 1'b1, ok);
    repeat (3) @(negedge CLK);
    en[0] = 1'b0;
    @(negedge CLK);
    total++; if (!ok || waveOut[0] !== 1'b0 || busy[0] !== 1'b0) begin bad++; $display("FAIL endrop_next_edge: wave %b busy %b expected 0 0", waveOut[0], busy[0]); end
    e = 0;
    for (int i = 0; i < 40; i++) begin
      if (period_done[0] !== 1'b0 || waveOut[0] !== 1'b0) e++;
      @(negedge CLK);
    end
    total++; if (e != 0) begin bad++; $display("FAIL endrop_quiet: bad samples %0d expected 0", e); end
  endtask

  task automatic test_rst_mid;
    bit ok; int e;
    do_reset;
    write_shadow(0, 2, 1, 0);
    write_shadow(1, 3, 0, 0);
    en = 4'b1111;
    wait_level(0, 1'b1, ok);
    total++; if (!ok || waveOut[1] !== 1'b1) begin bad++; $display("FAIL rst_pre_run: wave %b expected xx11", waveOut); end
    RST = 1'b1;
    @(negedge CLK);
    total++; if (waveOut !== 4'b0 || busy !== 4'b0 || period_done !== 4'b0) begin bad++; $display("FAIL rst_mid_clear: wave %b busy %b done %b expected 0000", waveOut, busy, period_done); end
    RST = 1'b0;
    e = 0;
    for (int i = 0; i < 100; i++) begin
      if (waveOut !== 4'b0 || busy !== 4'b0 || period_done !== 4'b0) e++;
      @(negedge CLK);
    end
    total++; if (e != 0) begin bad++; $display("FAIL rst_stays_low: bad samples %0d expected 0", e); end
  endtask

  initial begin
    test_reset;
    test_continuous;
    test_duty;
    test_oneshot;
    test_update;
    test_enable_drop;
    test_rst_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
